// File: rtl/wb_master_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_master_port
// Brief    : Wishbone B4 classic initiator; one outstanding transfer, bus
//            timeout, valid/ready command and response ports.
// Revision : 1.0 - initial release
// ============================================================================
module wb_master_port #(
    parameter int ADR_WIDTH      = 20,
    parameter int DAT_WIDTH      = 32,
    parameter int SEL_WIDTH      = DAT_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // command port
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADR_WIDTH-1:0] cmd_adr_i,
    input  logic [DAT_WIDTH-1:0] cmd_dat_i,
    input  logic [SEL_WIDTH-1:0] cmd_sel_i,
    // response port
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DAT_WIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    // wishbone initiator
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [ADR_WIDTH-1:0] adr_o,
    output logic [DAT_WIDTH-1:0] dat_o,
    output logic [SEL_WIDTH-1:0] sel_o,
    input  logic [DAT_WIDTH-1:0] dat_i,
    input  logic                 ack_i,
    input  logic                 err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int c_cnt_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_cnt_w'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;
    localparam bit                 c_tmo_en   = (TIMEOUT_CYCLES != 0);

    state_t               r_state,       w_state_nxt;
    logic                 r_cyc,         w_cyc_nxt;
    logic                 r_we,          w_we_nxt;
    logic [ADR_WIDTH-1:0] r_adr,         w_adr_nxt;
    logic [DAT_WIDTH-1:0] r_dat,         w_dat_nxt;
    logic [SEL_WIDTH-1:0] r_sel,         w_sel_nxt;
    logic [DAT_WIDTH-1:0] r_rsp_dat,     w_rsp_dat_nxt;
    logic                 r_rsp_err,     w_rsp_err_nxt;
    logic                 r_rsp_tmo,     w_rsp_tmo_nxt;
    logic [c_cnt_w-1:0]   r_cnt,         w_cnt_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
            r_rsp_tmo <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cyc     <= w_cyc_nxt;
            r_we      <= w_we_nxt;
            r_adr     <= w_adr_nxt;
            r_dat     <= w_dat_nxt;
            r_sel     <= w_sel_nxt;
            r_rsp_dat <= w_rsp_dat_nxt;
            r_rsp_err <= w_rsp_err_nxt;
            r_rsp_tmo <= w_rsp_tmo_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cyc_nxt     = r_cyc;
        w_we_nxt      = r_we;
        w_adr_nxt     = r_adr;
        w_dat_nxt     = r_dat;
        w_sel_nxt     = r_sel;
        w_rsp_dat_nxt = r_rsp_dat;
        w_rsp_err_nxt = r_rsp_err;
        w_rsp_tmo_nxt = r_rsp_tmo;
        w_cnt_nxt     = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_we_nxt    = cmd_we_i;
                    w_adr_nxt   = cmd_adr_i;
                    w_dat_nxt   = cmd_dat_i;
                    w_sel_nxt   = cmd_sel_i;
                    w_cyc_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BUS;
                end
            end

            S_BUS: begin
                // err has priority over a simultaneous ack
                if (err_i) begin
                    w_rsp_dat_nxt = '0;
                    w_rsp_err_nxt = 1'b1;
                    w_rsp_tmo_nxt = 1'b0;
                    w_cyc_nxt     = 1'b0;
                    w_state_nxt   = S_RESP;
                end else if (ack_i) begin
                    w_rsp_dat_nxt = r_we ? '0 : dat_i;
                    w_rsp_err_nxt = 1'b0;
                    w_rsp_tmo_nxt = 1'b0;
                    w_cyc_nxt     = 1'b0;
                    w_state_nxt   = S_RESP;
                end else if (c_tmo_en && (r_cnt == c_cnt_last)) begin
                    w_rsp_dat_nxt = '0;
                    w_rsp_err_nxt = 1'b1;
                    w_rsp_tmo_nxt = 1'b1;
                    w_cyc_nxt     = 1'b0;
                    w_state_nxt   = S_RESP;
                end else if (r_cnt != c_cnt_max) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_cyc_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // stb tracks cyc: classic single transfers never idle inside a cycle
    assign cyc_o         = r_cyc;
    assign stb_o         = r_cyc;
    assign we_o          = r_we;
    assign adr_o         = r_adr;
    assign dat_o         = r_dat;
    assign sel_o         = r_sel;
    assign cmd_ready_o   = (r_state == S_IDLE);
    assign rsp_valid_o   = (r_state == S_RESP);
    assign rsp_dat_o     = r_rsp_dat;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_tmo;

endmodule
`default_nettype wire

// File: doc/wb_master_port.md
Name: wb_master_port

Overview:
Synthesizable Wishbone classic (B4, non-pipelined) initiator. It converts single-transfer commands from an internal valid/ready command port into bus cycles on the shared wishbone_if, and returns read data and status on a valid/ready response port. It is the hardware counterpart to bus slaves such as xpm_ram, for use by CPU load/store units and debug bridges. It has one outstanding transfer at a time, and a bus timeout guards against slaves that never respond.

Parameters:
ADR_WIDTH, 20, Wishbone address width (word address).
DAT_WIDTH, 32, data width; must be a multiple of 8.
SEL_WIDTH, DAT_WIDTH/8, byte-select width (derived; not user-overridden).
TIMEOUT_CYCLES, 255, maximum wait cycles for ack/err; 0 disables the timeout.

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready at clock edge
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  ADR_WIDTH  target address
cmd_dat_i  in  DAT_WIDTH  write data
cmd_sel_i  in  SEL_WIDTH  byte enables
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&ready at clock edge
rsp_dat_o  out  DAT_WIDTH  read data (0 for writes)
rsp_err_o  out  1  slave err_i or timeout
rsp_timeout_o  out  1  response terminated by timeout
cyc_o, stb_o, we_o  out  1  Wishbone cycle/strobe/write-enable
adr_o  out  ADR_WIDTH  Wishbone address
dat_o  out  DAT_WIDTH  Wishbone write data
sel_o  out  SEL_WIDTH  Wishbone byte select
dat_i  in  DAT_WIDTH  Wishbone read data
ack_i, err_i  in  1  Wishbone termination

Behaviour:
- Clocking and reset: single clock; reset is synchronous, active-high. All Wishbone outputs are registered.
- Reset values: cyc_o=stb_o=we_o=0, adr_o/dat_o/sel_o=0, cmd_ready_o=1, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, rsp_timeout_o=0, timeout counter=0, state=IDLE.
- FSM:
  - IDLE: cmd_ready_o=1. On cmd_valid_i, latch we/adr/dat/sel into the bus registers, set cyc_o=stb_o=1, clear the counter, go to BUS.
  - BUS: cmd_ready_o=0. Hold cyc_o/stb_o/adr_o/dat_o/sel_o/we_o stable.
    - ack_i: capture dat_i (reads) or 0 (writes) into rsp_dat_o; rsp_err_o=0; drop cyc_o/stb_o; go to RESP.
    - err_i (alone or together with ack_i; err wins): rsp_err_o=1, rsp_dat_o=0; drop cyc/stb; go to RESP.
    - Neither, and counter==TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES≠0: rsp_err_o=1, rsp_timeout_o=1, rsp_dat_o=0; drop cyc/stb; go to RESP. Otherwise increment the counter, saturating.
  - RESP: rsp_valid_o=1, cmd_ready_o=0. On rsp_ready_i, rsp_valid_o←0 and return to IDLE. Response fields stay stable while rsp_valid_o is 1.
- Latency with a zero-wait slave (combinational ack): command accepted at edge N; cyc/stb high during cycle N+1; ack sampled at edge N+1; rsp_valid_o high in cycle N+2. Minimum command-to-command spacing is 3 cycles.
- cyc_o and stb_o are never deasserted in BUS before termination. ack_i/err_i are ignored outside BUS.
- Bus outputs are not cleared after termination; only cyc/stb drop. dat_o stays 0-irrelevant on reads.
- Reset mid-operation (BUS or RESP): cyc/stb drop at that edge and any pending response is discarded; no response is emitted for the aborted command.
- Timeout: with TIMEOUT_CYCLES=T, a non-responding slave sees cyc/stb asserted for exactly T cycles.

Test Plan:
- Write then read, zero-wait slave: write adr 0x00010, dat 0xDEADBEEF, sel 4'b1111; then read adr 0x00010 → write response err=0, dat=0; read rsp_dat_o=0xDEADBEEF; rsp_valid_o in cycle N+2 after each accept.
- Byte lanes: write 0x11223344 with sel 4'b0101 over 0x00000000, read back → 0x00220044; sel_o matches cmd_sel_i throughout BUS.
- Wait states plus response backpressure: slave acks after 5 cycles and rsp_ready_i is held low 4 cycles → cyc/stb high 6 cycles, stable adr/dat; rsp fields stable until handshake; cmd_ready_o=0 until rsp accepted.
- Error: slave asserts err_i together with ack_i on read of 0xFFFFF → rsp_err_o=1, rsp_timeout_o=0, rsp_dat_o=0.
- Timeout: TIMEOUT_CYCLES=8, no ack → cyc/stb high exactly 8 cycles, then rsp_err_o=1, rsp_timeout_o=1; the next command then completes normally.
- Reset mid-BUS: assert rst_i for 1 cycle during a wait-stated read → cyc_o=0 next cycle, rsp_valid_o never asserts, cmd_ready_o=1 after reset.
